// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit scheduler.
//   - uart_sched_state_t : scheduler FSM states
//   - BIT_PERIOD_W       : width of the transmitter bit-period register
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned BIT_PERIOD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        CFG
    } uart_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. The search starts at index
//   ptr and wraps around, so the first requester at or above ptr wins;
//   otherwise the lowest-indexed requester below ptr wins.
// Ports
//   req  in  N      request vector
//   ptr  in  PTR_W  index with highest priority this cycle (must be < N)
//   gnt  out N      one-hot grant, all zero when req is zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    // Two passes replace a modulo index: first the upper segment
    // [ptr, N-1], then the wrapped segment [0, ptr-1].
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one UART transmitter between NUM_REQ byte requesters. Round-robin
//   arbitration with packet lock: the granted requester keeps the link until
//   it sends a byte flagged last. Issues one-cycle start pulses, waits for the
//   transmitter's busy flag to rise and fall, and holds bit-period writes
//   until the link is idle so no frame changes baud midway.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid_i [N]     requester i has a byte
//   req_data_i  [8N]    byte of requester i at [8i+7:8i]
//   req_last_i  [N]     byte ends requester i's packet
//   req_ready_o [N]     byte of requester i accepted this cycle
//   cfg_wr_i            request a new bit period (last write wins)
//   cfg_bit_period_i    new bit period (clocks per bit - 1)
//   uart_tx_en_o        one-cycle start pulse to transmitter
//   uart_tx_data_o      byte to transmitter, held until the next accept
//   uart_tx_busy_i      transmitter busy
//   wr_bit_period_o     one-cycle bit-period write strobe
//   bit_period_o        bit-period value for that strobe
//   grant_o     [N]     one-hot current owner, zero when none
//   err_timeout_o       sticky: busy never rose after a start pulse
//   err_clr_i           clears err_timeout_o (a coincident timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [8*NUM_REQ-1:0]      req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      cfg_wr_i,
    input  logic [BIT_PERIOD_W-1:0]   cfg_bit_period_i,
    output logic                      uart_tx_en_o,
    output logic [7:0]                uart_tx_data_o,
    input  logic                      uart_tx_busy_i,
    output logic                      wr_bit_period_o,
    output logic [BIT_PERIOD_W-1:0]   bit_period_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      err_timeout_o,
    input  logic                      err_clr_i
);

    localparam int unsigned PTR_W  = $clog2(NUM_REQ);
    localparam int unsigned TCNT_W = $clog2(BUSY_TIMEOUT + 1);

    uart_sched_state_t        state_q, state_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                     lock_q, lock_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     cfg_pend_q, cfg_pend_d;
    logic [BIT_PERIOD_W-1:0]  cfg_val_q, cfg_val_d;
    logic                     err_q, err_d;
    logic [TCNT_W-1:0]        tcnt_q, tcnt_d;

    logic [NUM_REQ-1:0]       owner_oh;
    logic [NUM_REQ-1:0]       masked_req;
    logic [NUM_REQ-1:0]       arb_gnt;
    logic [NUM_REQ-1:0]       ready;
    logic                     cfg_go;
    logic                     in_flight;
    logic                     timeout;
    logic [PTR_W-1:0]         sel_idx;
    logic [7:0]               sel_data;
    logic                     sel_last;
    logic [PTR_W-1:0]         next_ptr;

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    // While locked only the owner may compete; an owner that drops valid
    // simply stalls the link.
    assign masked_req = lock_q ? (req_valid_i & owner_oh) : req_valid_i;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req (masked_req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Pending configuration takes precedence over data whenever the
    // transmitter is idle.
    assign cfg_go = cfg_pend_q & ~uart_tx_busy_i;
    assign ready  = ((state_q == IDLE) && !cfg_go) ? (arb_gnt & req_valid_i) : '0;

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                sel_idx  = PTR_W'(i);
                sel_data = req_data_i[8*i +: 8];
                sel_last = req_last_i[i];
            end
        end
    end

    assign next_ptr = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        owner_d    = owner_q;
        tx_data_d  = tx_data_q;
        cfg_pend_d = cfg_pend_q;
        cfg_val_d  = cfg_val_q;
        tcnt_d     = tcnt_q;
        timeout    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_go) begin
                    state_d = CFG;
                end else if (|ready) begin
                    tx_data_d = sel_data;
                    rr_ptr_d  = next_ptr;
                    lock_d    = ~sel_last;
                    owner_d   = sel_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Busy is sampled on BUSY_TIMEOUT cycles after the pulse;
                // the timeout fires in the last of them if it never rose.
                if (uart_tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (tcnt_q == TCNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    lock_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy_i) begin
                    state_d = IDLE;
                end
            end
            CFG: begin
                cfg_pend_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A write landing on the strobe cycle re-arms pending with the new value.
        if (cfg_wr_i) begin
            cfg_pend_d = 1'b1;
            cfg_val_d  = cfg_bit_period_i;
        end

        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            owner_q    <= '0;
            tx_data_q  <= '0;
            cfg_pend_q <= 1'b0;
            cfg_val_q  <= '0;
            err_q      <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            owner_q    <= owner_d;
            tx_data_q  <= tx_data_d;
            cfg_pend_q <= cfg_pend_d;
            cfg_val_q  <= cfg_val_d;
            err_q      <= err_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign in_flight       = (state_q == ISSUE) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign req_ready_o     = ready;
    assign uart_tx_en_o    = (state_q == ISSUE);
    assign uart_tx_data_o  = tx_data_q;
    assign wr_bit_period_o = (state_q == CFG);
    assign bit_period_o    = (state_q == CFG) ? cfg_val_q : '0;
    assign grant_o         = (lock_q || in_flight) ? owner_oh : '0;
    assign err_timeout_o   = err_q;

endmodule
